// File: rtl/cpu_pkg.sv
// Shared RV32I decode definitions: opcodes, instruction classes, ALU op encodings
// and the decoded bundle that flows from decode to execute.
package cpu_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    // ALU op field is funct3 verbatim for OP/OP-IMM
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SLL  = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b010;
    localparam logic [2:0] ALU_SLTU = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SR   = 3'b101;
    localparam logic [2:0] ALU_OR   = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b111;

    typedef enum logic [3:0] {
        CLASS_ALU     = 4'd0,
        CLASS_SHIFT   = 4'd1,
        CLASS_LUI     = 4'd2,
        CLASS_AUIPC   = 4'd3,
        CLASS_JAL     = 4'd4,
        CLASS_JALR    = 4'd5,
        CLASS_BRANCH  = 4'd6,
        CLASS_LOAD    = 4'd7,
        CLASS_STORE   = 4'd8,
        CLASS_ILLEGAL = 4'd9
    } instr_class_e;

    typedef struct packed {
        instr_class_e cls;
        logic [2:0]   alu_op;
        logic         do_sub;
        logic         use_imm;
        logic         cmp_unsigned;
        logic [31:0]  imm;
        logic [4:0]   rs1;
        logic [4:0]   rs2;
        logic [4:0]   rd;
        logic [2:0]   funct3;
    } decoded_t;

endpackage

// File: rtl/cpu_decode_comb.sv
// Purely combinational RV32I decode of one instruction word into a decoded_t bundle.
module cpu_decode_comb
    import cpu_pkg::*;
(
    input  logic [31:0] instr,
    output decoded_t    dec
);

    logic [6:0]   opcode;
    logic [6:0]   funct7;
    logic [2:0]   funct3;
    logic [31:0]  imm_i, imm_s, imm_b, imm_u, imm_j;
    logic         is_shift;
    logic         shift_f7_ok;
    logic         op_f7_ok;
    instr_class_e cls;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // The alternate funct7 only exists for SUB and SRA/SRAI
    assign is_shift    = (funct3 == ALU_SLL) || (funct3 == ALU_SR);
    assign shift_f7_ok = (funct7 == FUNCT7_BASE) || ((funct7 == FUNCT7_ALT) && (funct3 == ALU_SR));
    assign op_f7_ok    = (funct7 == FUNCT7_BASE) ||
                         ((funct7 == FUNCT7_ALT) && ((funct3 == ALU_ADD) || (funct3 == ALU_SR)));

    always_comb begin
        dec        = '0;
        cls        = CLASS_ILLEGAL;
        dec.rs1    = instr[19:15];
        dec.rs2    = instr[24:20];
        dec.rd     = instr[11:7];
        dec.funct3 = funct3;

        case (opcode)
            OPC_OP_IMM: begin
                dec.alu_op       = funct3;
                dec.use_imm      = 1'b1;
                dec.cmp_unsigned = (funct3 == ALU_SLTU);
                dec.imm          = imm_i;
                if (!is_shift)        cls = CLASS_ALU;
                else if (shift_f7_ok) cls = CLASS_SHIFT;
            end
            OPC_OP: begin
                dec.alu_op       = funct3;
                dec.cmp_unsigned = (funct3 == ALU_SLTU);
                dec.do_sub       = (funct3 == ALU_ADD) && (funct7 == FUNCT7_ALT);
                if (op_f7_ok) cls = is_shift ? CLASS_SHIFT : CLASS_ALU;
            end
            OPC_BRANCH: begin
                dec.cmp_unsigned = funct3[1];
                dec.imm          = imm_b;
                dec.rd           = 5'd0;
                if (funct3[2:1] != 2'b01) cls = CLASS_BRANCH;
            end
            OPC_LOAD: begin
                dec.use_imm = 1'b1;
                dec.imm     = imm_i;
                cls         = CLASS_LOAD;
            end
            OPC_STORE: begin
                dec.use_imm = 1'b1;
                dec.imm     = imm_s;
                dec.rd      = 5'd0;
                cls         = CLASS_STORE;
            end
            OPC_JALR: begin
                dec.use_imm = 1'b1;
                dec.imm     = imm_i;
                cls         = CLASS_JALR;
            end
            OPC_LUI: begin
                dec.use_imm = 1'b1;
                dec.imm     = imm_u;
                cls         = CLASS_LUI;
            end
            OPC_AUIPC: begin
                dec.use_imm = 1'b1;
                dec.imm     = imm_u;
                cls         = CLASS_AUIPC;
            end
            OPC_JAL: begin
                dec.imm = imm_j;
                cls     = CLASS_JAL;
            end
            default: cls = CLASS_ILLEGAL;
        endcase

        // Illegal bundles still travel downstream, but carry no controls and no rd
        if (cls == CLASS_ILLEGAL) begin
            dec.alu_op       = ALU_ADD;
            dec.do_sub       = 1'b0;
            dec.use_imm      = 1'b0;
            dec.cmp_unsigned = 1'b0;
            dec.imm          = '0;
            dec.rd           = 5'd0;
        end
        dec.cls = cls;
    end

endmodule

// File: rtl/cpu_decode.sv
// Decode pipeline stage: valid/ready handshake around cpu_decode_comb with
// registered outputs and a branch-redirect flush.
module cpu_decode
    import cpu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_instr_i,
    input  logic [31:0] in_pc_i,
    input  logic        flush_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_pc_o,
    output logic [4:0]  out_rs1_o,
    output logic [4:0]  out_rs2_o,
    output logic [4:0]  out_rd_o,
    output logic [31:0] out_imm_o,
    output logic [2:0]  out_alu_op_o,
    output logic        out_do_sub_o,
    output logic        out_use_imm_o,
    output logic        out_cmp_unsigned_o,
    output logic [3:0]  out_class_o,
    output logic [2:0]  out_funct3_o
);

    decoded_t    dec_next;
    decoded_t    dec_q;
    logic [31:0] pc_q;
    logic        valid_q;
    logic        capture;

    cpu_decode_comb u_comb (
        .instr (in_instr_i),
        .dec   (dec_next)
    );

    assign in_ready_o = !valid_q || out_ready_i;
    assign capture    = in_valid_i && in_ready_o && !flush_i;

    // Flush beats capture beats consume; the bundle only changes on capture so it holds through stalls
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            dec_q   <= '0;
            pc_q    <= '0;
        end else begin
            if (flush_i)          valid_q <= 1'b0;
            else if (capture)     valid_q <= 1'b1;
            else if (out_ready_i) valid_q <= 1'b0;

            if (capture) begin
                dec_q <= dec_next;
                pc_q  <= in_pc_i;
            end
        end
    end

    assign out_valid_o        = valid_q;
    assign out_pc_o           = pc_q;
    assign out_rs1_o          = dec_q.rs1;
    assign out_rs2_o          = dec_q.rs2;
    assign out_rd_o           = dec_q.rd;
    assign out_imm_o          = dec_q.imm;
    assign out_alu_op_o       = dec_q.alu_op;
    assign out_do_sub_o       = dec_q.do_sub;
    assign out_use_imm_o      = dec_q.use_imm;
    assign out_cmp_unsigned_o = dec_q.cmp_unsigned;
    assign out_class_o        = dec_q.cls;
    assign out_funct3_o       = dec_q.funct3;

endmodule

// File: tb/tb_cpu_decode.sv
// Directed bench for cpu_decode: decode vectors, back-pressure, flush and reset.
module tb_cpu_decode;
    import cpu_pkg::*;

    logic        clk_i;
    logic        rst_ni;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_instr_i;
    logic [31:0] in_pc_i;
    logic        flush_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_pc_o;
    logic [4:0]  out_rs1_o;
    logic [4:0]  out_rs2_o;
    logic [4:0]  out_rd_o;
    logic [31:0] out_imm_o;
    logic [2:0]  out_alu_op_o;
    logic        out_do_sub_o;
    logic        out_use_imm_o;
    logic        out_cmp_unsigned_o;
    logic [3:0]  out_class_o;
    logic [2:0]  out_funct3_o;

    int errors;
    int checks;

    cpu_decode dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .in_valid_i         (in_valid_i),
        .in_ready_o         (in_ready_o),
        .in_instr_i         (in_instr_i),
        .in_pc_i            (in_pc_i),
        .flush_i            (flush_i),
        .out_valid_o        (out_valid_o),
        .out_ready_i        (out_ready_i),
        .out_pc_o           (out_pc_o),
        .out_rs1_o          (out_rs1_o),
        .out_rs2_o          (out_rs2_o),
        .out_rd_o           (out_rd_o),
        .out_imm_o          (out_imm_o),
        .out_alu_op_o       (out_alu_op_o),
        .out_do_sub_o       (out_do_sub_o),
        .out_use_imm_o      (out_use_imm_o),
        .out_cmp_unsigned_o (out_cmp_unsigned_o),
        .out_class_o        (out_class_o),
        .out_funct3_o       (out_funct3_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkField(input string tag, input string field,
                              input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s/%s: observed %h expected %h", tag, field, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] instr, input logic [31:0] pc,
                                 input logic flush, input logic ready);
        in_valid_i  = valid;
        in_instr_i  = instr;
        in_pc_i     = pc;
        flush_i     = flush;
        out_ready_i = ready;
        #1;
    endtask

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic checkOutput(input string tag, input logic valid, input logic [3:0] cls,
                               input logic [2:0] alu_op, input logic do_sub, input logic use_imm,
                               input logic cmp_unsigned, input logic [31:0] imm,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                               input logic [31:0] pc, input logic [2:0] funct3);
        checkField(tag, "valid",   32'(out_valid_o),        32'(valid));
        checkField(tag, "class",   32'(out_class_o),        32'(cls));
        checkField(tag, "alu_op",  32'(out_alu_op_o),       32'(alu_op));
        checkField(tag, "do_sub",  32'(out_do_sub_o),       32'(do_sub));
        checkField(tag, "use_imm", 32'(out_use_imm_o),      32'(use_imm));
        checkField(tag, "cmp_uns", 32'(out_cmp_unsigned_o), 32'(cmp_unsigned));
        checkField(tag, "imm",     out_imm_o,               imm);
        checkField(tag, "rs1",     32'(out_rs1_o),          32'(rs1));
        checkField(tag, "rs2",     32'(out_rs2_o),          32'(rs2));
        checkField(tag, "rd",      32'(out_rd_o),           32'(rd));
        checkField(tag, "pc",      out_pc_o,                pc);
        checkField(tag, "funct3",  32'(out_funct3_o),       32'(funct3));
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_ni = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        #1;
        checkOutput("reset", 1'b0, CLASS_ALU, 3'd0, 0, 0, 0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 3'd0);
        checkField("reset", "in_ready", 32'(in_ready_o), 32'd1);

        @(negedge clk_i);
        rst_ni = 1'b1;

        // Back-to-back decode vectors at full throughput
        applyStimulus(1'b1, 32'h00500093, 32'h100, 1'b0, 1'b1);
        step();
        checkOutput("addi", 1'b1, CLASS_ALU, 3'd0, 0, 1, 0, 32'd5, 5'd0, 5'd5, 5'd1, 32'h100, 3'd0);
        checkField("addi", "in_ready", 32'(in_ready_o), 32'd1);

        applyStimulus(1'b1, 32'h402081B3, 32'h104, 1'b0, 1'b1);
        step();
        checkOutput("sub", 1'b1, CLASS_ALU, 3'd0, 1, 0, 0, 32'h0, 5'd1, 5'd2, 5'd3, 32'h104, 3'd0);

        applyStimulus(1'b1, 32'h0020E463, 32'h108, 1'b0, 1'b1);
        step();
        checkOutput("bltu", 1'b1, CLASS_BRANCH, 3'd0, 0, 0, 1, 32'd8, 5'd1, 5'd2, 5'd0, 32'h108, 3'd6);

        applyStimulus(1'b1, 32'h00000000, 32'h10C, 1'b0, 1'b1);
        step();
        checkOutput("zero", 1'b1, CLASS_ILLEGAL, 3'd0, 0, 0, 0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h10C, 3'd0);

        applyStimulus(1'b1, 32'h022081B3, 32'h110, 1'b0, 1'b1);
        step();
        checkOutput("mul", 1'b1, CLASS_ILLEGAL, 3'd0, 0, 0, 0, 32'h0, 5'd1, 5'd2, 5'd0, 32'h110, 3'd0);

        applyStimulus(1'b1, 32'h402091B3, 32'h114, 1'b0, 1'b1);
        step();
        checkOutput("sll_alt", 1'b1, CLASS_ILLEGAL, 3'd0, 0, 0, 0, 32'h0, 5'd1, 5'd2, 5'd0, 32'h114, 3'd1);

        applyStimulus(1'b1, 32'h0020B233, 32'h118, 1'b0, 1'b1);
        step();
        checkOutput("sltu", 1'b1, CLASS_ALU, 3'd3, 0, 0, 1, 32'h0, 5'd1, 5'd2, 5'd4, 32'h118, 3'd3);

        applyStimulus(1'b1, 32'h4030D293, 32'h11C, 1'b0, 1'b1);
        step();
        checkOutput("srai", 1'b1, CLASS_SHIFT, 3'd5, 0, 1, 0, 32'h403, 5'd1, 5'd3, 5'd5, 32'h11C, 3'd5);

        applyStimulus(1'b1, 32'h123452B7, 32'h120, 1'b0, 1'b1);
        step();
        checkOutput("lui", 1'b1, CLASS_LUI, 3'd0, 0, 1, 0, 32'h12345000, 5'd8, 5'd3, 5'd5, 32'h120, 3'd5);

        applyStimulus(1'b1, 32'hFE20AE23, 32'h124, 1'b0, 1'b1);
        step();
        checkOutput("sw", 1'b1, CLASS_STORE, 3'd0, 0, 1, 0, 32'hFFFFFFFC, 5'd1, 5'd2, 5'd0, 32'h124, 3'd2);

        applyStimulus(1'b1, 32'h010000EF, 32'h128, 1'b0, 1'b1);
        step();
        checkOutput("jal", 1'b1, CLASS_JAL, 3'd0, 0, 0, 0, 32'd16, 5'd0, 5'd16, 5'd1, 32'h128, 3'd0);

        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        step();
        checkField("drain", "valid", 32'(out_valid_o), 32'd0);

        // Back-pressure: hold addi for three cycles while sub is offered
        applyStimulus(1'b1, 32'h00500093, 32'h200, 1'b0, 1'b1);
        step();
        applyStimulus(1'b1, 32'h402081B3, 32'h204, 1'b0, 1'b0);
        checkField("stall", "in_ready", 32'(in_ready_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("stall", 1'b1, CLASS_ALU, 3'd0, 0, 1, 0, 32'd5, 5'd0, 5'd5, 5'd1, 32'h200, 3'd0);
            checkField("stall", "in_ready", 32'(in_ready_o), 32'd0);
        end
        applyStimulus(1'b1, 32'h402081B3, 32'h204, 1'b0, 1'b1);
        checkField("release", "in_ready", 32'(in_ready_o), 32'd1);
        step();
        checkOutput("release", 1'b1, CLASS_ALU, 3'd0, 1, 0, 0, 32'h0, 5'd1, 5'd2, 5'd3, 32'h204, 3'd0);

        // Flush while a bundle is held and another is offered
        applyStimulus(1'b1, 32'h0020E463, 32'h300, 1'b1, 1'b1);
        checkField("flush", "in_ready", 32'(in_ready_o), 32'd1);
        step();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        checkField("flush", "valid", 32'(out_valid_o), 32'd0);
        checkField("flush", "pc", out_pc_o, 32'h204);
        checkField("flush", "class", 32'(out_class_o), 32'(CLASS_ALU));
        step();
        checkField("flush_after", "valid", 32'(out_valid_o), 32'd0);

        // Reset arriving mid-stall clears everything without a clock edge
        applyStimulus(1'b1, 32'h0020E463, 32'h400, 1'b0, 1'b1);
        step();
        applyStimulus(1'b1, 32'h00500093, 32'h404, 1'b0, 1'b0);
        step();
        checkField("prestall", "valid", 32'(out_valid_o), 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        checkOutput("midreset", 1'b0, CLASS_ALU, 3'd0, 0, 0, 0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 3'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        applyStimulus(1'b1, 32'h010000EF, 32'h500, 1'b0, 1'b1);
        checkField("postreset", "in_ready", 32'(in_ready_o), 32'd1);
        step();
        checkOutput("postreset", 1'b1, CLASS_JAL, 3'd0, 0, 0, 0, 32'd16, 5'd0, 5'd16, 5'd1, 32'h500, 3'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_decode.md
CPU_DECODE -- requirements
Module: cpu_decode

Interface
REQ-001 clk_i  input  1  single clock; all state updates on rising edge.
REQ-002 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-003 in_valid_i  input  1  fetch presents an instruction.
REQ-004 in_ready_o  output  1  decoder accepts an instruction this cycle.
REQ-005 in_instr_i  input  32  raw RV32I instruction word.
REQ-006 in_pc_i  input  32  PC of that instruction.
REQ-007 flush_i  input  1  discard the held and incoming instruction (branch redirect).
REQ-008 out_valid_o  output  1  decoded bundle valid.
REQ-009 out_ready_i  input  1  execute stage consumes the bundle.
REQ-010 out_pc_o  output  32, plus out_rs1_o/out_rs2_o/out_rd_o  output  5 each: registered PC and register indices.
REQ-011 out_imm_o  output  32  sign-extended immediate.
REQ-012 out_alu_op_o  output  3, out_do_sub_o  output  1, out_use_imm_o  output  1, out_cmp_unsigned_o  output  1: ALU controls in ALU encoding (ADD 000, SLT 01x, XOR 100, OR 110, AND 111).
REQ-013 out_class_o  output  4  instruction class enum: ALU, SHIFT, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, ILLEGAL.
REQ-014 out_funct3_o  output  3  raw funct3, for branch condition and load/store width.

Function
REQ-015 Single registered stage: decode is combinational from in_instr_i; the result is captured into output registers on in_valid_i && in_ready_o, so latency is 1 cycle.
REQ-016 in_ready_o SHALL equal !out_valid_o || out_ready_i, so full throughput is 1 instr/cycle and there are no bubbles while the execute stage is ready.
REQ-017 While out_valid_o && !out_ready_i, all out_* SHALL hold stable.
REQ-018 out_valid_o next cycle: 0 if flush_i; else 1 if a capture occurs; else 0 if out_ready_i; else hold.
REQ-019 flush_i SHALL drop any instruction offered in the same cycle, with in_ready_o still asserted, and clear out_valid_o next cycle; flush has priority over simultaneous capture and consume.
REQ-020 Immediate formats: I (OP-IMM, LOAD, JALR), S (STORE), B (BRANCH, bit0=0), U (LUI, AUIPC, low 12 bits 0), J (JAL, bit0=0); all other classes produce 0.
REQ-021 OP/OP-IMM: alu_op = funct3; do_sub = 1 only for OP with funct3=000 and funct7=0100000; cmp_unsigned = funct3[0] for SLT/SLTU; use_imm = 1 for OP-IMM.
REQ-022 funct3 001/101 classify as SHIFT. Legal funct7 for shifts: 0000000, or 0100000 only with funct3=101.
REQ-023 BRANCH: alu_op=000, use_imm=0, cmp_unsigned=funct3[1]; funct3 010/011 are ILLEGAL.
REQ-024 LOAD, STORE, JALR, LUI, AUIPC, JAL: alu_op=000, do_sub=0; use_imm=1 for all except JAL.
REQ-025 Any unlisted opcode, any OP funct7 outside 0000000/0100000, and any OP funct7=0100000 with funct3 outside 000/101 classify as ILLEGAL, with all ALU controls 0; an ILLEGAL bundle is still delivered with out_valid_o=1.
REQ-026 rd SHALL read as 0 for BRANCH, STORE and ILLEGAL.

Reset
REQ-027 Asserting rst_ni low SHALL immediately clear out_valid_o and all out_* registers to 0, with class 0 = ALU; this includes reset arriving mid-stall.
REQ-028 After reset release, in_ready_o=1 and the first capture is allowed on the first rising edge.

Structure
REQ-029 The opcode constants, the class enum and the ALU op encodings SHALL live in a shared package cpu_pkg, which cpu_alu also imports.
REQ-030 Combinational decode SHALL be one sub-module, cpu_decode_comb; cpu_decode holds only the handshake and output registers.

Verification
REQ-031 0x00500093 (addi x1,x0,5) -> one cycle later: valid, class ALU, op 000, use_imm 1, imm 5, rd 1.
REQ-032 0x402081B3 (sub x3,x1,x2) -> do_sub 1, use_imm 0, rs1 1, rs2 2, rd 3.
REQ-033 0x0020E463 (bltu x1,x2,+8) -> class BRANCH, imm 8, cmp_unsigned 1, rd 0.
REQ-034 0x00000000 and 0x022081B3 (M-extension) -> class ILLEGAL, valid 1, ALU controls 0.
REQ-035 out_ready_i low for 3 cycles with a new instruction offered -> in_ready_o 0 and outputs stable; out_ready_i high -> the held bundle drains and the next is captured in the same cycle.
REQ-036 flush_i with in_valid_i=1 and out_valid_o=1 -> out_valid_o 0 next cycle, offered instruction never appears; reset asserted mid-stall -> out_valid_o 0 immediately.
